mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Shares the 32-bit 4:1 datapath mux (mux_4x1_32b, instantiated internally) between four requesters using round-robin arbitration.
- Drives the mux select from the arbitration result and registers the winning word into a single-entry output slot with a valid/ready handshake.
- Supports optional burst locking, bounded by a starvation guard.
- Sits between the four data producers and any single-word consumer in the datapath.

Parameters:
- LOCK_MAX, 8: maximum consecutive grants to one locked requester before forced release; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  4  request per requester; bit i = requester i
- lock  in  4  lock request per requester; only meaningful with req[i]
- d0  in  32  requester 0 data
- d1  in  32  requester 1 data
- d2  in  32  requester 2 data
- d3  in  32  requester 3 data
- out_ready  in  1  consumer accepts out_data this cycle
- gnt  out  4  one-hot grant, combinational; req[i] & gnt[i] = transfer accepted this cycle
- sel  out  2  select currently applied to the internal mux, combinational
- out_valid  out  1  output slot holds a word, registered
- out_data  out  32  registered winning word
- out_src  out  2  index of the requester that produced out_data, registered
- locked  out  1  high while in the LOCKED state, registered

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_src=0, locked=0.
  - Round-robin pointer ptr=0, state=IDLE, burst counter cnt=0.
  - gnt=0 while rst is high.
- slot_free = !out_valid | out_ready. No grant is issued when slot_free=0, so gnt=0 under backpressure.
- IDLE state, slot_free=1, req!=0:
  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - gnt = one-hot(w); sel = w.
  - Next edge: out_data = mux output (d_w), out_src=w, out_valid=1, ptr=(w+1) mod 4.
  - If lock[w]=1: go to LOCKED with owner=w, cnt=1, locked=1.
- IDLE or LOCKED, slot_free=1, no eligible req: gnt=0. If out_ready=1, out_valid clears next edge. out_data and out_src hold their last value.
- LOCKED state (owner o):
  - Only requester o is eligible. Other requests are ignored; those requesters stall.
  - While slot_free=1 and req[o]=1: gnt[o]=1, sel=o, word captured next edge, cnt increments.
  - Exit to IDLE at the edge where any of these holds: req[o]=0; lock[o]=0 on a granted cycle (that word is still transferred); cnt reaches LOCK_MAX on a granted cycle.
  - On exit: locked=0, cnt=0, ptr=(o+1) mod 4.
  - Backpressure does not count toward cnt and does not cause exit.
- sel when gnt=0: holds out_src, so the mux output stays stable.
- Latency: 1 cycle from grant to out_valid. Throughput is 1 word/cycle when out_ready stays high.
- Simultaneous drain and fill (out_valid=1, out_ready=1, new grant): the slot is overwritten at the edge with no bubble, and out_valid stays 1.
- Pointer wrap: ptr 3 -> 0.
- Reset mid-burst or under backpressure: the held word is dropped and the lock is released immediately.
- Requester data must be stable during its grant cycle only.

Test Plan:
1. Reset, single requester: assert rst, then release. req=0001, d0=32'h01234567, out_ready=1 -> gnt=0001 in the same cycle; next cycle out_valid=1, out_data=32'h01234567, out_src=0; ptr=1.
2. Round-robin fairness: req=1111, d0..d3 = 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, with matching out_data every cycle and no bubbles.
3. Backpressure: out_valid=1 holding 32'h89ABCDEF, out_ready=0 for 3 cycles, req=1111 -> gnt=0, and out_data/out_src/out_valid are unchanged. Then out_ready=1 -> the next round-robin winner is granted in that cycle.
4. Lock burst: req=0101, lock=0100, ptr=2 -> out_src=2 repeated with locked=1 while req[0] is ignored. Drop lock[2] -> that final word transfers, locked=0, and the next grant goes to requester 0.
5. Starvation guard: LOCK_MAX=8, requester 3 holds req and lock continuously, req[1]=1 -> exactly 8 consecutive grants to requester 3, then locked=0 and the next grant goes to requester 1.
6. Async reset mid-burst: assert rst between clock edges while locked=1 and out_valid=1 -> out_valid, locked and gnt go to 0 immediately, without waiting for a clock edge. After release, req=1000 -> grant is issued from ptr=0 and out_src=3.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing a 32-bit 4:1 mux into a registered output slot
// Optional per-requester burst lock, bounded by LOCK_MAX consecutive grants.

module mux_4x1_32b (
   input  logic [1:0]  sel,
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   output logic [31:0] y
);
   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end
endmodule

module mux_rr_arbiter #(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [3:0]  lock,
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   input  logic        out_ready,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [1:0]  out_src,
   output logic        locked
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

   logic [0:0]  state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [1:0]  out_src_q, out_src_d;

   logic        slot_free;
   logic        found;
   logic        eligible;
   logic        grant;
   logic [1:0]  rr_win;
   logic [1:0]  win;
   logic [1:0]  idx;
   logic [3:0]  cnt_inc;
   logic [31:0] mux_y;

   mux_4x1_32b u_mux (
      .sel (sel),
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .y   (mux_y)
   );

   always_comb begin
      slot_free = !out_valid_q | out_ready;
      found     = 1'b0;
      rr_win    = ptr_q;
      idx       = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            rr_win = idx;
         end
      end
      if (state_q == LOCKED) begin
         win      = owner_q;
         eligible = req[owner_q];
      end else begin
         win      = rr_win;
         eligible = found;
      end
      // rst gates the grant so gnt drops the instant reset is asserted
      grant = slot_free & eligible & !rst;
      gnt   = grant ? (4'b0001 << win) : 4'b0000;
      sel   = grant ? win : out_src_q;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      cnt_inc     = cnt_q + 4'd1;

      if (grant) begin
         out_data_d  = mux_y;
         out_src_d   = win;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (grant) begin
               ptr_d = win + 2'd1;
               if (lock[win] && (LOCK_MAX > 1)) begin
                  state_d = LOCKED;
                  owner_d = win;
                  cnt_d   = 4'd1;
               end
            end
         end
         default: begin
            if (!req[owner_q] ||
                (grant && (!lock[owner_q] || cnt_inc >= LOCK_MAX_C))) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
               ptr_d   = owner_q + 2'd1;
            end else if (grant) begin
               cnt_d = cnt_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         owner_q     <= 2'd0;
         cnt_q       <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_src_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign locked    = (state_q == LOCKED);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
// Expected words are queued when grants are driven and popped as the consumer takes them.

module tb_mux_rr_arbiter;
   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] d0, d1, d2, d3;
   logic        out_ready;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_src;
   logic        locked;

   int vectors;
   int miscompares;
   logic [33:0] sb_q[$];

   localparam logic [31:0] D0 = 32'h01234567;
   localparam logic [31:0] D1 = 32'h89ABCDEF;
   localparam logic [31:0] D2 = 32'hFEDCBA98;
   localparam logic [31:0] D3 = 32'h76543210;

   mux_rr_arbiter #(.LOCK_MAX(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .lock      (lock),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // consumer: a word leaves the slot at the edge following a negedge with valid & ready
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [33:0] exp_w;
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_unexpected: got src=%0d data=%h, required no word", out_src, out_data);
         end else begin
            exp_w = sb_q.pop_front();
            if ({out_src, out_data} !== exp_w) begin
               miscompares++;
               $display("FAIL scoreboard_word: got src=%0d data=%h, required src=%0d data=%h",
                        out_src, out_data, exp_w[33:32], exp_w[31:0]);
            end
         end
      end
   end

   function automatic logic [31:0] dval(input int i);
      case (i)
         0:       return D0;
         1:       return D1;
         2:       return D2;
         default: return D3;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      lock = 4'b0000;
      out_ready = 1'b1;
      tick();
      sb_q.delete();
      rst = 1'b0;
   endtask

   task automatic drain();
      req = 4'b0000;
      lock = 4'b0000;
      out_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0001;
      lock = 4'b0000;
      out_ready = 1'b1;
      #2;
      vectors++;
      if ({gnt, out_valid, locked, out_data, out_src} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_state: got gnt=%b valid=%b locked=%b data=%h src=%0d, required all zero",
                  gnt, out_valid, locked, out_data, out_src);
      end
      tick();
      rst = 1'b0;
      sb_q.delete();
      req = 4'b0001;
      sb_q.push_back({2'd0, D0});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001 || sel !== 2'd0) begin
         miscompares++;
         $display("FAIL single_gnt: got gnt=%b sel=%0d, required 0001 sel=0", gnt, sel);
      end
      tick();
      req = 4'b0000;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || gnt !== 4'b0000 || sel !== 2'd0) begin
         miscompares++;
         $display("FAIL single_out: got valid=%b gnt=%b sel=%0d, required 1 0000 0", out_valid, gnt, sel);
      end
      tick();
      req = 4'b0011;
      sb_q.push_back({2'd1, D1});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("FAIL ptr_after_first: got gnt=%b, required 0010", gnt);
      end
      tick();
      drain();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_valid: got %b, required 0", out_valid);
      end
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         sb_q.push_back({2'(i % 4), dval(i % 4)});
         @(negedge clk);
         vectors++;
         if (gnt !== (4'b0001 << (i % 4)) || (i > 0 && out_valid !== 1'b1)) begin
            miscompares++;
            $display("FAIL rr_cycle%0d: got gnt=%b valid=%b, required gnt=%b valid=1",
                     i, gnt, out_valid, 4'b0001 << (i % 4));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 4'b0011;
      sb_q.push_back({2'd0, D0});
      tick();
      sb_q.push_back({2'd1, D1});
      tick();
      req = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_data !== D1 || out_src !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got gnt=%b valid=%b data=%h src=%0d, required 0000 1 %h 1",
                     i, gnt, out_valid, out_data, out_src, D1);
         end
         tick();
      end
      out_ready = 1'b1;
      sb_q.push_back({2'd2, D2});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_release: got gnt=%b, required 0100", gnt);
      end
      tick();
      drain();
   endtask

   task automatic test_lock_burst();
      do_reset();
      req = 4'b0010;
      sb_q.push_back({2'd1, D1});
      tick();
      req = 4'b0101;
      lock = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back({2'd2, D2});
         @(negedge clk);
         vectors++;
         if (gnt !== 4'b0100 || locked !== (i > 0)) begin
            miscompares++;
            $display("FAIL lock_burst%0d: got gnt=%b locked=%b, required 0100 %0d", i, gnt, locked, i > 0);
         end
         tick();
      end
      lock = 4'b0000;
      sb_q.push_back({2'd2, D2});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0100 || locked !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_final: got gnt=%b locked=%b, required 0100 1", gnt, locked);
      end
      tick();
      sb_q.push_back({2'd0, D0});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL lock_release: got gnt=%b locked=%b, required 0001 0", gnt, locked);
      end
      tick();
      drain();
   endtask

   task automatic test_starvation();
      do_reset();
      req = 4'b1000;
      lock = 4'b1000;
      sb_q.push_back({2'd3, D3});
      tick();
      req = 4'b1010;
      for (int i = 1; i < 8; i++) begin
         sb_q.push_back({2'd3, D3});
         @(negedge clk);
         vectors++;
         if (gnt !== 4'b1000 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL starve_grant%0d: got gnt=%b locked=%b, required 1000 1", i, gnt, locked);
         end
         tick();
      end
      sb_q.push_back({2'd1, D1});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0010 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL starve_release: got gnt=%b locked=%b, required 0010 0", gnt, locked);
      end
      tick();
      drain();
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      lock = 4'b0100;
      sb_q.push_back({2'd2, D2});
      tick();
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || locked !== 1'b0 || gnt !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%b locked=%b gnt=%b, required 0 0 0000",
                  out_valid, locked, gnt);
      end
      sb_q.delete();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      lock = 4'b0000;
      req = 4'b1000;
      sb_q.push_back({2'd3, D3});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b1000) begin
         miscompares++;
         $display("FAIL post_reset_gnt: got gnt=%b, required 1000", gnt);
      end
      tick();
      req = 4'b0011;
      sb_q.push_back({2'd0, D0});
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++;
         $display("FAIL post_reset_wrap: got gnt=%b, required 0001", gnt);
      end
      tick();
      drain();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      d0 = D0;
      d1 = D1;
      d2 = D2;
      d3 = D3;
      rst = 1'b1;
      req = 4'b0000;
      lock = 4'b0000;
      out_ready = 1'b1;
      #1;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_lock_burst();
      test_starvation();
      test_async_reset();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: got %0d words pending, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
